// File: rtl/scpu_prog_loader_pkg.sv
// Shared SCPU definitions: opcodes plus the program-loader state encoding
// and frame header length.
package scpu_prog_loader_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LD  = 4'h1,
        OP_ST  = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_JMP = 4'h8,
        OP_JZ  = 4'h9,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CHK,
        ST_START,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    localparam int HDR_LEN = 4;

    // Only bit 0 of addr_hi / len_hi is meaningful; anything above it is a bad header.
    function automatic logic hiByteBad(input logic [7:0] b);
        return |b[7:1];
    endfunction

endpackage

// File: rtl/scpu_prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
interface scpu_prog_loader_if #(parameter int ADDR_W = 9);

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_dataout;

    modport master (
        input  in_valid, in_data,
        output in_ready, mem_sel, mem_addr, mem_we, mem_dataout
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, mem_sel, mem_addr, mem_we, mem_dataout
    );

endinterface

// File: rtl/scpu_prog_loader_cksum.sv
// 8-bit modulo-sum accumulator; o_zero flags that the running sum plus the
// current operand wraps to zero, which is how the checksum byte is judged.
module scpu_ld_cksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_add,
    input  logic [7:0] i_byte,
    output logic       o_zero
);

    logic [7:0] r_sum;
    logic [7:0] w_next;

    assign w_next = r_sum + i_byte;
    assign o_zero = (w_next == 8'h00);

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_sum <= 8'h00;
        else if (i_add)
            r_sum <= w_next;
    end

endmodule

// File: rtl/scpu_prog_loader.sv
// Receives a framed program image over a byte stream, writes it into SCPU
// memory and optionally kicks the CPU once the checksum verifies.
module scpu_prog_loader
    import scpu_prog_loader_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter bit AUTO_START = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load_req,
    input  logic                i_abort,
    scpu_prog_loader_if.master  bus,
    output logic                o_cpu_enable,
    output logic                o_cpu_start,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

    ld_state_e         r_state;
    ld_state_e         w_nextState;
    logic [1:0]        r_hdrCnt;
    logic [7:0]        r_addrLo;
    logic [7:0]        r_lenLo;
    logic [8:0]        r_remain;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [7:0]        r_memData;

    logic       w_rxState;
    logic       w_accept;
    logic       w_loadOk;
    logic       w_cksumZero;
    logic       w_lastHdr;
    logic [8:0] w_len;

    assign w_rxState = (r_state == ST_HDR) || (r_state == ST_DATA) || (r_state == ST_CHK);
    // Abort beats a byte offered in the same cycle, so the byte is never taken.
    assign w_accept  = w_rxState && bus.in_valid && !i_abort;
    assign w_loadOk  = i_load_req &&
                       ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_lastHdr = (r_hdrCnt == 2'(HDR_LEN - 1));
    assign w_len     = {bus.in_data[0], r_lenLo};

    scpu_ld_cksum u_cksum (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_loadOk),
        .i_add  (w_accept && (r_state == ST_DATA)),
        .i_byte (bus.in_data),
        .o_zero (w_cksumZero)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState     = r_state;
        bus.in_ready    = w_rxState;
        bus.mem_sel     = w_rxState || r_memWe;
        o_busy          = w_rxState;
        o_cpu_start     = 1'b0;
        o_cpu_enable    = 1'b0;
        o_done          = 1'b0;
        o_err           = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                o_done       = (r_state == ST_DONE);
                o_err        = (r_state == ST_ERR);
                o_cpu_enable = (r_state == ST_DONE);
                if (i_load_req)
                    w_nextState = ST_HDR;
            end
            ST_HDR: begin
                if (i_abort)
                    w_nextState = ST_ERR;
                else if (w_accept) begin
                    if (r_hdrCnt[0] && hiByteBad(bus.in_data))
                        w_nextState = ST_ERR;
                    else if (w_lastHdr)
                        w_nextState = (w_len == 9'd0) ? ST_CHK : ST_DATA;
                end
            end
            ST_DATA: begin
                if (i_abort)
                    w_nextState = ST_ERR;
                else if (w_accept && (r_remain == 9'd1))
                    w_nextState = ST_CHK;
            end
            ST_CHK: begin
                if (i_abort)
                    w_nextState = ST_ERR;
                else if (w_accept) begin
                    if (!w_cksumZero)
                        w_nextState = ST_ERR;
                    else
                        w_nextState = AUTO_START ? ST_START : ST_DONE;
                end
            end
            ST_START: begin
                o_busy       = 1'b1;
                o_cpu_start  = 1'b1;
                o_cpu_enable = 1'b1;
                w_nextState  = ST_DONE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Header capture and the one-cycle-delayed memory write for each payload byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdrCnt  <= 2'd0;
            r_addrLo  <= 8'h00;
            r_lenLo   <= 8'h00;
            r_remain  <= 9'd0;
            r_ptr     <= '0;
            r_memWe   <= 1'b0;
            r_memAddr <= '0;
            r_memData <= 8'h00;
        end else begin
            r_memWe <= 1'b0;
            if (w_loadOk)
                r_hdrCnt <= 2'd0;
            if (w_accept) begin
                case (r_state)
                    ST_HDR: begin
                        r_hdrCnt <= r_hdrCnt + 2'd1;
                        case (r_hdrCnt)
                            2'd0:    r_addrLo <= bus.in_data;
                            2'd1:    r_ptr    <= ADDR_W'({bus.in_data[0], r_addrLo});
                            2'd2:    r_lenLo  <= bus.in_data;
                            default: r_remain <= w_len;
                        endcase
                    end
                    ST_DATA: begin
                        r_memWe   <= 1'b1;
                        r_memAddr <= r_ptr;
                        r_memData <= bus.in_data;
                        r_ptr     <= r_ptr + ADDR_W'(1);
                        r_remain  <= r_remain - 9'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.mem_we      = r_memWe;
    assign bus.mem_addr    = r_memAddr;
    assign bus.mem_dataout = r_memData;

endmodule

// File: tb/tb_scpu_prog_loader.sv
// Directed bench for scpu_prog_loader: a cycle table for a good frame, then
// hand-written sequences for error, wrap, abort, reset and gapped-stream cases.
module tb_scpu_prog_loader;

    logic clk;
    logic rst;
    logic loadReq;
    logic abort;
    logic cpuEnable;
    logic cpuStart;
    logic busy;
    logic done;
    logic err;

    scpu_prog_loader_if #(.ADDR_W(9)) bus ();

    scpu_prog_loader #(.ADDR_W(9), .AUTO_START(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_load_req   (loadReq),
        .i_abort      (abort),
        .bus          (bus),
        .o_cpu_enable (cpuEnable),
        .o_cpu_start  (cpuStart),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        lr;
        logic        ab;
        logic        v;
        logic [7:0]  d;
        logic [24:0] exp;
    } vec_t;

    vec_t        vecs[13];
    int          checks;
    int          fails;
    int          writeCnt;
    int          startCnt;
    logic [7:0]  shadow[512];
    logic [16:0] wlog[$];
    logic [7:0]  frameQ[$];

    // Memory and CPU-start observer, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            shadow[bus.mem_addr] = bus.mem_dataout;
            writeCnt++;
            wlog.push_back({bus.mem_addr, bus.mem_dataout});
        end
        if (cpuStart === 1'b1)
            startCnt++;
    end

    function automatic vec_t mkVec(input logic lr, ab, v, input logic [7:0] d,
                                   input logic rdy, sel, we, input logic [8:0] addr,
                                   input logic [7:0] dout, input logic en, st, bz, dn, er);
        vec_t r;
        r.lr  = lr;
        r.ab  = ab;
        r.v   = v;
        r.d   = d;
        r.exp = {rdy, sel, we, addr, dout, en, st, bz, dn, er};
        return r;
    endfunction

    function automatic logic [24:0] sampleOutputs();
        return {bus.in_ready, bus.mem_sel, bus.mem_we, bus.mem_addr, bus.mem_dataout,
                cpuEnable, cpuStart, busy, done, err};
    endfunction

    task automatic applyStimulus(input logic lr, ab, v, input logic [7:0] d);
        loadReq      = lr;
        abort        = ab;
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        loadReq      = 1'b0;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sendBytes(input int maxGap);
        for (int i = 0; i < frameQ.size(); i++) begin
            if (maxGap > 0)
                repeat ($urandom_range(maxGap, 0)) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
            applyStimulus(1'b0, 1'b0, 1'b1, frameQ[i]);
        end
    endtask

    task automatic sendFrame(input int maxGap);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        sendBytes(maxGap);
    endtask

    task automatic clearLog();
        writeCnt = 0;
        startCnt = 0;
        wlog.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        checks       = 0;
        fails        = 0;
        writeCnt     = 0;
        startCnt     = 0;
        rst          = 1'b1;
        loadReq      = 1'b0;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        for (int i = 0; i < 512; i++) shadow[i] = 8'hEE;

        // Good frame 20 00 04 00 | AB 00 00 3C | 19, one row per cycle.
        //                lr ab v  d       rdy sel we addr   dout   en st bz dn er
        vecs[0]  = mkVec(1, 0, 0, 8'h00,  0, 0, 0, 9'd0,  8'h00, 0, 0, 0, 0, 0);
        vecs[1]  = mkVec(0, 0, 1, 8'h20,  1, 1, 0, 9'd0,  8'h00, 0, 0, 1, 0, 0);
        vecs[2]  = mkVec(0, 0, 1, 8'h00,  1, 1, 0, 9'd0,  8'h00, 0, 0, 1, 0, 0);
        vecs[3]  = mkVec(0, 0, 1, 8'h04,  1, 1, 0, 9'd0,  8'h00, 0, 0, 1, 0, 0);
        vecs[4]  = mkVec(0, 0, 1, 8'h00,  1, 1, 0, 9'd0,  8'h00, 0, 0, 1, 0, 0);
        vecs[5]  = mkVec(0, 0, 1, 8'hAB,  1, 1, 0, 9'd0,  8'h00, 0, 0, 1, 0, 0);
        vecs[6]  = mkVec(0, 0, 1, 8'h00,  1, 1, 1, 9'd32, 8'hAB, 0, 0, 1, 0, 0);
        vecs[7]  = mkVec(0, 0, 1, 8'h00,  1, 1, 1, 9'd33, 8'h00, 0, 0, 1, 0, 0);
        vecs[8]  = mkVec(0, 0, 1, 8'h3C,  1, 1, 1, 9'd34, 8'h00, 0, 0, 1, 0, 0);
        vecs[9]  = mkVec(0, 0, 1, 8'h19,  1, 1, 1, 9'd35, 8'h3C, 0, 0, 1, 0, 0);
        vecs[10] = mkVec(0, 0, 0, 8'h00,  0, 0, 0, 9'd35, 8'h3C, 1, 1, 1, 0, 0);
        vecs[11] = mkVec(0, 0, 1, 8'h55,  0, 0, 0, 9'd35, 8'h3C, 1, 0, 0, 1, 0);
        vecs[12] = mkVec(0, 0, 0, 8'h00,  0, 0, 0, 9'd35, 8'h3C, 1, 0, 0, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            checkOutput($sformatf("row%0d", i), 32'(sampleOutputs()), 32'(vecs[i].exp));
            applyStimulus(vecs[i].lr, vecs[i].ab, vecs[i].v, vecs[i].d);
        end
        checkOutput("good_starts", startCnt, 1);
        checkOutput("good_writes", writeCnt, 4);

        // load_req with abort in DONE opens a frame; stray load_req mid-header is ignored.
        clearLog();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("ldabort_busy", {busy, err, bus.in_ready}, 3'b101);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h20);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        frameQ = '{8'h00, 8'h04, 8'h00, 8'hAB, 8'h00, 8'h00, 8'h3C, 8'h18};
        sendBytes(0);
        checkOutput("bad_status", {err, done, cpuEnable}, 3'b100);
        idle(2);
        checkOutput("bad_starts", startCnt, 0);
        checkOutput("bad_writes", writeCnt, 4);
        checkOutput("bad_mem", {shadow[32], shadow[33], shadow[34], shadow[35]}, 32'hAB00003C);

        // Pointer wrap from 511 to 0.
        clearLog();
        frameQ = '{8'hFF, 8'h01, 8'h02, 8'h00, 8'h11, 8'h22, 8'hCD};
        sendFrame(0);
        idle(2);
        checkOutput("wrap_cnt", wlog.size(), 2);
        checkOutput("wrap_w0", 32'(wlog[0]), 32'({9'd511, 8'h11}));
        checkOutput("wrap_w1", 32'(wlog[1]), 32'({9'd0, 8'h22}));
        checkOutput("wrap_done", {done, cpuEnable, startCnt[0]}, 3'b111);

        // Zero-length frame, then a header with a bad addr_hi byte.
        clearLog();
        frameQ = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        sendFrame(0);
        idle(2);
        checkOutput("zero_writes", writeCnt, 0);
        checkOutput("zero_starts", startCnt, 1);
        checkOutput("zero_done", done, 1'b1);
        frameQ = '{8'h00, 8'h02};
        sendFrame(0);
        checkOutput("hdr_err", {err, busy, bus.in_ready}, 3'b100);

        // Abort with the third payload byte of a four-byte frame.
        clearLog();
        frameQ = '{8'h40, 8'h00, 8'h04, 8'h00, 8'h01, 8'h02};
        sendFrame(0);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h03);
        checkOutput("abort_err", {err, busy}, 2'b10);
        idle(2);
        checkOutput("abort_writes", writeCnt, 2);
        checkOutput("abort_last", 32'(wlog[wlog.size()-1]), 32'({9'h41, 8'h02}));

        // Reset mid-DATA together with an offered byte.
        clearLog();
        frameQ = '{8'h50, 8'h00, 8'h04, 8'h00, 8'h01};
        sendFrame(0);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h02;
        @(posedge clk);
        #1;
        checkOutput("rst_outputs", 32'(sampleOutputs()), 32'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h03);
        idle(2);
        checkOutput("rst_writes", writeCnt, 1);

        // Same good frame with random 0..3 cycle gaps between bytes.
        clearLog();
        for (int i = 32; i < 36; i++) shadow[i] = 8'hEE;
        frameQ = '{8'h20, 8'h00, 8'h04, 8'h00, 8'hAB, 8'h00, 8'h00, 8'h3C, 8'h19};
        sendFrame(3);
        idle(3);
        checkOutput("gap_mem", {shadow[32], shadow[33], shadow[34], shadow[35]}, 32'hAB00003C);
        checkOutput("gap_writes", writeCnt, 4);
        checkOutput("gap_starts", startCnt, 1);
        checkOutput("gap_done", {done, cpuEnable, err}, 3'b110);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
